// File: rtl/seq_alu.sv
// seq_alu -- handshaked, parametrised execute-stage ALU.
//
// Takes one operation per valid/ready handshake and presents its registered
// result behind a second valid/ready pair. Multiply (shift-add) and divide
// (restoring) iterate one bit per cycle; every other op takes one cycle.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  operation handshake; in_ready is high only in IDLE
//   opselect, x, y       op code and operands, latched on acceptance
//   out_valid/out_ready  result handshake; outputs held stable in DONE
//   res, rem             result (quotient for div), remainder (div only)
//   v, c_out, zero       overflow, carry, result-is-zero flags
//
// Configuration macro: SEQ_ALU_SIGNED_EN
//   defined   -> gt/lt and div use two's-complement signed operands
//   undefined -> all compares and div are unsigned
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opselect,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] rem,
    output logic             v,
    output logic             c_out,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
                           OP_SHL = 4'h4, OP_SHR = 4'h5, OP_GT  = 4'h6, OP_LT  = 4'h7,
                           OP_EQ  = 4'h8, OP_AND = 4'h9, OP_OR  = 4'hA, OP_NAND = 4'hB,
                           OP_NOR = 4'hC, OP_XOR = 4'hD, OP_XNOR = 4'hE;
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0]  md_q, md_d, hi_q, hi_d, lo_q, lo_d;
    logic [SHW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]  res_q, res_d, rem_q, rem_d;
    logic              v_q, v_d, c_q, c_d, zero_q, zero_d;

    logic [WIDTH-1:0]  sc_res, fin_res, fin_rem, b_eff, x_op, y_op;
    logic              sc_v, sc_c, fin_v, is_sub, is_multi, gt, lt;
    logic [WIDTH:0]    sc_sum, mul_sum;
    logic signed [WIDTH+1:0] div_trial;

`ifdef SEQ_ALU_SIGNED_EN
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] a);
        return a[WIDTH-1] ? -a : a;
    endfunction
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign rem       = rem_q;
    assign v         = v_q;
    assign c_out     = c_q;
    assign zero      = zero_q;

    assign is_multi = (op_q == OP_MUL) || (op_q == OP_DIV);

    // Signed div works on magnitudes; mul always stays unsigned.
`ifdef SEQ_ALU_SIGNED_EN
    assign x_op = (opselect == OP_DIV) ? mag(x) : x;
    assign y_op = (opselect == OP_DIV) ? mag(y) : y;
    assign gt   = $signed(x_q) > $signed(y_q);
    assign lt   = $signed(x_q) < $signed(y_q);
`else
    assign x_op = x;
    assign y_op = y;
    assign gt   = x_q > y_q;
    assign lt   = x_q < y_q;
`endif

    // Single-cycle ops: sub is x + ~y + 1 through the same adder as add.
    always_comb begin
        is_sub = (op_q == OP_SUB);
        b_eff  = is_sub ? ~y_q : y_q;
        sc_sum = {1'b0, x_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        sc_res = '0;
        sc_v   = 1'b0;
        sc_c   = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                sc_res = sc_sum[WIDTH-1:0];
                sc_c   = sc_sum[WIDTH];
                sc_v   = (x_q[WIDTH-1] == b_eff[WIDTH-1]) && (sc_sum[WIDTH-1] != x_q[WIDTH-1]);
            end
            OP_SHL:  sc_res = x_q << y_q[SHW-1:0];
            OP_SHR:  sc_res = x_q >> y_q[SHW-1:0];
            OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, gt};
            OP_LT:   sc_res = {{(WIDTH-1){1'b0}}, lt};
            OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, x_q == y_q};
            OP_AND:  sc_res = x_q & y_q;
            OP_OR:   sc_res = x_q | y_q;
            OP_NAND: sc_res = ~(x_q & y_q);
            OP_NOR:  sc_res = ~(x_q | y_q);
            OP_XOR:  sc_res = x_q ^ y_q;
            OP_XNOR: sc_res = ~(x_q ^ y_q);
            default: sc_res = '0;
        endcase
    end

    // Iteration datapath. {hi,lo} is the product shift register for mul and
    // the {partial remainder, dividend/quotient} pair for div. The trial
    // subtraction is two bits wider than the divisor so that y==0 (where the
    // remainder invariant does not hold) still yields all-ones and rem=x.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : {(WIDTH+1){1'b0}});
        div_trial = $signed({1'b0, hi_q, lo_q[WIDTH-1]}) - $signed({2'b00, md_q});
        fin_res   = lo_q;
        fin_rem   = '0;
        fin_v     = 1'b0;
        if (op_q == OP_MUL) begin
            fin_v = |hi_q;
        end else if (y_q == '0) begin
            fin_res = '1;
            fin_rem = x_q;
            fin_v   = 1'b1;
        end else begin
`ifdef SEQ_ALU_SIGNED_EN
            fin_res = (x_q[WIDTH-1] ^ y_q[WIDTH-1]) ? -lo_q : lo_q;
            fin_rem = x_q[WIDTH-1] ? -hi_q : hi_q;
            fin_v   = (x_q == {1'b1, {(WIDTH-1){1'b0}}}) && (y_q == '1);
`else
            fin_rem = hi_q;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        md_d    = md_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rem_d   = rem_q;
        v_d     = v_q;
        c_d     = c_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = EXEC;
                    op_d    = opselect;
                    x_d     = x;
                    y_d     = y;
                    md_d    = y_op;
                    lo_d    = x_op;
                    hi_d    = '0;
                    cnt_d   = '0;
                end
            end
            EXEC: begin
                if (!is_multi) begin
                    state_d = DONE;
                    res_d   = sc_res;
                    rem_d   = '0;
                    v_d     = sc_v;
                    c_d     = sc_c;
                    zero_d  = (sc_res == '0);
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + (SHW+1)'(1);
                    if (op_q == OP_MUL) begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end else begin
                        hi_d = div_trial[WIDTH+1] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]}
                                                  : div_trial[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
                    end
                end else begin
                    // Extra cycle after the last bit applies sign/zero fix-ups.
                    state_d = DONE;
                    res_d   = fin_res;
                    rem_d   = fin_rem;
                    v_d     = fin_v;
                    c_d     = 1'b0;
                    zero_d  = (fin_res == '0);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            md_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            md_q    <= md_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            v_q     <= v_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    localparam int W = 32;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   opselect;
    logic [W-1:0] x, y, res, rem;
    logic         v, c_out, zero;
    logic [W-1:0] prev_res;
    int           n_chk = 0;
    int           n_pass = 0;

    seq_alu #(.WIDTH(W), .SHW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opselect(opselect), .x(x), .y(y), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .rem(rem), .v(v), .c_out(c_out), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: plain arithmetic on 64-bit values.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [W-1:0] rm,
                         output logic vf, output logic cf);
        logic [63:0] w;
        longint sa, sb, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; rm = '0; vf = 1'b0; cf = 1'b0;
        case (op)
            4'h0: begin
                w = {32'b0, a} + {32'b0, b}; r = w[31:0]; cf = w[32];
                t = sa + sb; vf = (t > SMAX) || (t < SMIN);
            end
            4'h1: begin
                w = {32'b0, a} + {32'b0, ~b} + 64'd1; r = w[31:0]; cf = w[32];
                t = sa - sb; vf = (t > SMAX) || (t < SMIN);
            end
            4'h2: begin
                w = {32'b0, a} * {32'b0, b}; r = w[31:0]; vf = (w[63:32] != 0);
            end
            4'h3: begin
                if (b == 0) begin
                    r = '1; rm = a; vf = 1'b1;
                end else begin
`ifdef SEQ_ALU_SIGNED_EN
                    if (sa == SMIN && sb == -1) begin
                        r = 32'h8000_0000; rm = 0; vf = 1'b1;
                    end else begin
                        t = sa / sb; r = t[31:0];
                        t = sa % sb; rm = t[31:0];
                    end
`else
                    r = a / b; rm = a % b;
`endif
                end
            end
            4'h4: r = a << b[4:0];
            4'h5: r = a >> b[4:0];
`ifdef SEQ_ALU_SIGNED_EN
            4'h6: r = {31'b0, sa > sb};
            4'h7: r = {31'b0, sa < sb};
`else
            4'h6: r = {31'b0, a > b};
            4'h7: r = {31'b0, a < b};
`endif
            4'h8: r = {31'b0, a == b};
            4'h9: r = a & b;
            4'hA: r = a | b;
            4'hB: r = ~(a & b);
            4'hC: r = ~(a | b);
            4'hD: r = a ^ b;
            4'hE: r = ~(a ^ b);
            default: r = '0;
        endcase
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold);
        logic [W-1:0] er, erm;
        logic ev, ec;
        int lat, exp_lat;
        bit seen, rdy_bad;
        model(op, a, b, er, erm, ev, ec);
        exp_lat = (op == 4'h2 || op == 4'h3) ? W + 1 : 1;
        @(negedge clk);
        check("rdy_idle", in_ready, 1);
        in_valid = 1'b1; opselect = op; x = a; y = b;
        @(posedge clk); #1;
        // Noise while busy must be ignored.
        in_valid = 1'($urandom_range(0, 1)); opselect = 4'($urandom); x = $urandom; y = $urandom;
        check("busy_rdy", in_ready, 0);
        check("exec_hold", res, prev_res);
        lat = 0; seen = 0; rdy_bad = 0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) seen = 1;
            else if (in_ready) rdy_bad = 1;
        end
        if (!seen) check("timeout", 0, 1);
        check("latency", lat, exp_lat);
        check("rdy_busy", rdy_bad, 0);
        check("res", res, er);
        check("rem", rem, erm);
        check("v", v, ev);
        check("c_out", c_out, ec);
        check("zero", zero, er == 0);
        in_valid = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        check("hold_valid", out_valid, 1);
        check("hold_res", {rem, res}, {erm, er});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_valid", out_valid, 0);
        check("hs_rdy", in_ready, 1);
        check("idle_res", res, er);
        prev_res = er;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opselect = '0; x = '0; y = '0;
        prev_res = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_out", {rem, res}, 64'd0);
        check("rst_flags", {v, c_out, zero}, 3'b001);
        @(negedge clk); rst = 1'b0;

        do_op(4'h0, 32'hFFFF_FFFF, 32'h1, 0);
        do_op(4'h1, 32'h8000_0000, 32'h1, 0);
        do_op(4'h2, 32'h0001_0000, 32'h0001_0000, 0);
        do_op(4'h3, 32'd100, 32'd7, 1);
        do_op(4'h3, 32'd5, 32'd0, 0);
        do_op(4'h4, 32'h1, 32'd31, 5);
        do_op(4'h6, 32'hFFFF_FFFF, 32'h1, 0);
        do_op(4'h3, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(4'h5, 32'h8000_0000, 32'd0, 0);
        do_op(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        // Reset in the middle of a divide.
        @(negedge clk);
        in_valid = 1'b1; opselect = 4'h3; x = 32'd1000; y = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_rdy", in_ready, 1);
        check("mid_rst_res", {zero, res}, {1'b1, 32'd0});
        @(negedge clk); rst = 1'b0;
        prev_res = '0;
        do_op(4'h0, 32'd20, 32'd22, 0);

        for (int i = 0; i < 48; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 9));
                1: a = 32'($urandom_range(0, 300));
                default: ;
            endcase
            do_op(4'($urandom), a, b, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
